// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C write target (and its optional read path).
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK,
        SUB,
        WDATA,
        IGNORE,
        RDATA
    } state_t;

    localparam logic       ACK_BIT       = 1'b0;
    localparam logic       NAK_BIT       = 1'b1;
    localparam logic       RW_WRITE      = 1'b0;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchronizer for one I2C pad line with rise/fall strobes.
// The strobes stay quiet until the edge-history flop holds a real sample after reset.
module i2c_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [2:0] primed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            prev_q   <= 1'b1;
            primed_q <= 3'b000;
        end else begin
            meta_q   <= async_in;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            primed_q <= {primed_q[1:0], 1'b1};
        end
    end

    // Without the primed gate a low pad seen right after reset would look like an edge.
    assign sync_out = sync_q;
    assign rise     = primed_q[2] &  sync_q & ~prev_q;
    assign fall     = primed_q[2] & ~sync_q &  prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C register-write target: START, address, sub-address, then auto-incrementing writes.
// Define I2C_TARGET_READ_EN to add the read path (rd_data/rd_addr ports and RDATA state).
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
`ifdef I2C_TARGET_READ_EN
    input  logic [7:0] rd_data,
    output logic [7:0] rd_addr,
`endif
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic scl_sync, scl_rise, scl_fall;
    logic sda_sync, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t     state, state_nxt;
    state_t     ack_next, ack_next_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift_q, shift_nxt;
    logic [7:0] tx_q, tx_nxt;
    logic [7:0] pointer, pointer_nxt;
    logic       busy_nxt, wr_en_nxt, sda_oe_nxt;
    logic [7:0] wr_addr_nxt, wr_data_nxt;

    i2c_sync u_scl_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (scl_in),
        .sync_out (scl_sync),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_sync u_sda_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sda_in),
        .sync_out (sda_sync),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    assign start_det = sda_fall & scl_sync;
    assign stop_det  = sda_rise & scl_sync;

`ifdef I2C_TARGET_READ_EN
    assign rd_addr = pointer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ack_next <= IDLE;
            bit_cnt  <= 4'd0;
            shift_q  <= 8'h00;
            tx_q     <= 8'hFF;
            pointer  <= 8'h00;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_next <= ack_next_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift_q  <= shift_nxt;
            tx_q     <= tx_nxt;
            pointer  <= pointer_nxt;
            busy     <= busy_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            sda_oe   <= sda_oe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ack_next_nxt = ack_next;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_q;
        tx_nxt       = tx_q;
        pointer_nxt  = pointer;
        busy_nxt     = busy;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;

        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = 4'd0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 4'd0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, SUB, WDATA: begin
                    if (scl_rise && bit_cnt < BITS_PER_BYTE) begin
                        shift_nxt   = {shift_q[6:0], sda_sync};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (state == WDATA && bit_cnt == BITS_PER_BYTE - 4'd1) begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = pointer;
                            wr_data_nxt = {shift_q[6:0], sda_sync};
                            pointer_nxt = pointer + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
                        // Byte complete: enter the ACK slot, or walk away with SDA released.
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = ACK;
                        case (state)
                            ADDR: begin
                                if (shift_q[7:1] != I2C_ADDR) begin
                                    state_nxt = IGNORE;
                                end else if (shift_q[0] == RW_WRITE) begin
                                    busy_nxt     = 1'b1;
                                    ack_next_nxt = SUB;
                                end else begin
`ifdef I2C_TARGET_READ_EN
                                    busy_nxt     = 1'b1;
                                    ack_next_nxt = RDATA;
`else
                                    state_nxt    = IGNORE;
`endif
                                end
                            end
                            SUB: begin
                                pointer_nxt  = shift_q;
                                ack_next_nxt = WDATA;
                            end
                            default: ack_next_nxt = WDATA;
                        endcase
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        state_nxt   = ack_next;
                        bit_cnt_nxt = 4'd0;
`ifdef I2C_TARGET_READ_EN
                        tx_nxt      = rd_data;
`endif
                    end
                end
                RDATA: begin
                    // bit_cnt counts scl falls here so SDA only moves while SCL is low.
                    if (scl_fall) begin
                        if (bit_cnt == BITS_PER_BYTE - 4'd1) begin
                            bit_cnt_nxt = BITS_PER_BYTE;
                            pointer_nxt = pointer + 8'd1;
                        end else if (bit_cnt == BITS_PER_BYTE) begin
                            bit_cnt_nxt = 4'd0;
`ifdef I2C_TARGET_READ_EN
                            tx_nxt      = rd_data;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                            tx_nxt      = {tx_q[6:0], 1'b1};
                        end
                    end else if (scl_rise && bit_cnt == BITS_PER_BYTE && sda_sync == NAK_BIT) begin
                        state_nxt = IGNORE;
                    end
                end
                default: ;
            endcase
        end

        sda_oe_nxt = (state_nxt == ACK) ||
                     (state_nxt == RDATA && bit_cnt_nxt < BITS_PER_BYTE && tx_nxt[7] == ACK_BIT);
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h70, the 7-bit target address this block responds to.
REQ-002 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port scl_in, input, 1 bit: raw SCL from pad, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1 bit: raw SDA from pad, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 means pull SDA low (open-drain); the pad output data is tied 0 outside this block.
REQ-007 SHALL have port wr_en, output, 1 bit: single-cycle register-write strobe.
REQ-008 SHALL have port wr_addr, output, 8 bits: register sub-address for wr_en.
REQ-009 SHALL have port wr_data, output, 8 bits: data for wr_en.
REQ-010 SHALL have port busy, output, 1 bit: high between an addressed START and the next STOP.

Function
REQ-011 SHALL pass scl_in and sda_in through 2-FF synchronizers and derive scl rise/fall and sda rise/fall from the synchronized values.
REQ-012 SHALL detect START (sda fall while scl high) and STOP (sda rise while scl high) in every state.
REQ-013 SHALL sample SDA on scl rise, MSB first, and shift 8 bits per byte.
REQ-014 SHALL implement states IDLE, ADDR, ACK, SUB, WDATA, IGNORE.
REQ-015 SHALL go to ADDR on START from any state, including a repeated START, and go to IDLE on STOP from any state.
REQ-016 SHALL compare bits[7:1] of the ADDR byte with I2C_ADDR: on a match with R/W=0, SHALL ACK and then go to SUB; otherwise it SHALL NOT ACK and SHALL go to IGNORE until the next START or STOP.
REQ-017 SHALL ACK the SUB byte, load it into an internal pointer, and go to WDATA.
REQ-018 SHALL pulse wr_en for one clk, 1 cycle after the scl rise of the 8th WDATA bit, with wr_addr=pointer and wr_data=the byte.
REQ-019 SHALL ACK every WDATA byte and increment the pointer modulo 256 after each write (0xFF wraps to 0x00).
REQ-020 SHALL drive sda_oe high from the scl fall after the 8th bit until the scl fall after the 9th bit when ACKing; sda_oe SHALL be 0 at all other times.
REQ-021 SHALL discard a partial byte terminated by START or STOP and SHALL NOT pulse wr_en for it.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0 and synchronizers=1.
REQ-023 SHALL, after reset is released mid-transfer, ignore bus activity until the next START.

Configuration
REQ-024 SHALL, with macro I2C_TARGET_READ_EN defined, add input rd_data[7:0] and output rd_addr[7:0]=pointer.
REQ-025 SHALL, with I2C_TARGET_READ_EN defined, ACK a matched address with R/W=1 and enter state RDATA.
REQ-026 SHALL, in RDATA, drive each rd_data bit MSB-first, changing only after scl fall.
REQ-027 SHALL, in RDATA, increment the pointer after each byte and sample the master ACK.
REQ-028 SHALL, in RDATA, go to IGNORE on a master NAK.
REQ-029 SHALL, without I2C_TARGET_READ_EN, NAK a matched address with R/W=1 and go to IGNORE; the rd_* ports SHALL be absent in that build.

Structure
REQ-030 SHALL place the state enum and the ACK and bit-count constants in package i2c_target_pkg.
REQ-031 SHALL instantiate the sub-module i2c_sync (2-FF synchronizer plus rise/fall detect) once for SCL and once for SDA.

Verification
REQ-032 Write 0xE0, 0x0A, 0x55, 0x1F, STOP -> 4 ACKs; wr pulses (0x0A,0x55) then (0x0B,0x1F); busy falls at STOP.
REQ-033 Write to address 0x71 (byte 0xE2), 0x0A, 0x55 -> NAK on the address byte; no wr_en; sda_oe never 1.
REQ-034 Sub-address 0xFF with data 0x11, 0x22 -> writes (0xFF,0x11) then (0x00,0x22).
REQ-035 START, 0xE0, 0x05, 4 data bits, repeated START, 0xE0, 0x06, 0x33 -> exactly 1 write, (0x06,0x33).
REQ-036 rst_n pulsed low mid-WDATA, bus finishes the byte -> no wr_en and no ACK; the next full transaction works.
REQ-037 With READ_EN: set sub-address 0x03, then repeated START, 0xE1, rd_data=0xA5 -> master reads 0xA5; rd_addr steps 0x03 to 0x04.
